ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, meaning instruction-queue entries and maximum outstanding memory requests (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port pc_start, input, 32 bits: boot fetch address, held stable while rst is high.
REQ-005 SHALL have port redirect_valid, input, 1 bit: single-cycle redirect (branch/jump) request.
REQ-006 SHALL have port redirect_pc, input, 32 bits: new fetch address, valid with redirect_valid.
REQ-007 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-008 SHALL have port imem_req_ready, input, 1 bit: memory accepts request.
REQ-009 SHALL have port imem_req_addr, output, 32 bits: fetch address.
REQ-010 SHALL have port imem_rsp_valid, input, 1 bit: response valid, in order, exactly one per accepted request, never in the acceptance cycle.
REQ-011 SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-012 SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst_data (output, 32), inst_pc (output, 32): decode-side valid/ready stream.
REQ-013 SHALL have port fetch_fault, output, 1 bit: misaligned fetch address flag.

Function
REQ-014 SHALL hold fetch_pc (next request address) and rsp_pc (address of next expected non-discarded response); imem_req_addr = fetch_pc.
REQ-015 SHALL assert imem_req_valid iff not in reset, redirect_valid low, fault not blocking, and outstanding + queue count < QDEPTH.
REQ-016 SHALL, on request handshake (imem_req_valid & imem_req_ready), increment outstanding and advance fetch_pc by 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-017 SHALL, on a non-discarded response, decrement outstanding, push {rsp_pc, imem_rsp_data} into the queue and advance rsp_pc by 4; entry visible at inst_valid the next cycle (no bypass).
REQ-018 SHALL drive inst_valid = queue not empty, with inst_data/inst_pc from the queue head; pop on inst_valid & inst_ready; push and pop in the same cycle are both honoured.
REQ-019 SHALL hold inst_data/inst_pc stable while inst_valid is high and inst_ready is low.
REQ-020 SHALL, on redirect_valid: flush the queue (same-cycle pop ignored); set fetch_pc and rsp_pc to redirect_pc; set drop_cnt to outstanding minus 1 if imem_rsp_valid is high that cycle, else to outstanding; discard any response arriving that cycle.
REQ-021 SHALL discard responses while drop_cnt > 0, decrementing drop_cnt and outstanding, without pushing to the queue or advancing rsp_pc.
REQ-022 SHALL give minimum latency: request accepted cycle N, response N+1, inst_valid N+2; first request may issue in the first cycle after rst deasserts.
REQ-023 SHALL never overflow the queue; credit rule REQ-015 guarantees space for every outstanding response.

Reset
REQ-024 SHALL, while rst is high: fetch_pc = rsp_pc = pc_start; queue empty; outstanding = drop_cnt = 0; imem_req_valid = 0, inst_valid = 0, fetch_fault = 0.
REQ-025 SHALL discard all in-flight responses on reset assertion mid-operation; the memory side is reset concurrently, so no late responses arrive.

Configuration
REQ-026 SHALL, with IFETCH_ALIGN_FAULT_EN defined: when fetch_pc[1:0] != 0, suppress requests and assert fetch_fault (sticky) until a redirect to an aligned address or reset; queued entries still drain.
REQ-027 SHALL, with IFETCH_ALIGN_FAULT_EN undefined: tie fetch_fault to 0 and drive imem_req_addr with bits [1:0] forced to 0.

Verification
REQ-028 SHALL cover: pc_start=0x1000, ready always 1, 1-cycle response, inst_ready=1 -> inst_pc 0x1000,0x1004,0x1008 on consecutive cycles, first inst_valid 2 cycles after first handshake.
REQ-029 SHALL cover: inst_ready=0 with QDEPTH=2 -> exactly 2 requests accepted, then imem_req_valid low; inst_data/inst_pc stable until inst_ready rises.
REQ-030 SHALL cover: redirect to 0x2000 with 2 requests outstanding -> both responses dropped, queue empty, next inst_pc 0x2000.
REQ-031 SHALL cover: redirect in the same cycle as a response and an inst pop -> response dropped, pop ignored, drop_cnt = outstanding-1, first delivered inst_pc = redirect_pc.
REQ-032 SHALL cover: fetch_pc 0xFFFFFFFC -> next request address 0x00000000; and redirect to 0x2002 -> fetch_fault=1, no requests with IFETCH_ALIGN_FAULT_EN; imem_req_addr=0x2000, fetch_fault=0 without it.
REQ-033 SHALL cover: rst asserted with requests outstanding and queue full -> outputs at reset values asynchronously, fetch restarts from pc_start.

Source files
------------

// File: rtl/ifetch_unit.sv
// In-order instruction fetch: credit-limited request issue, in-order response tracking and a small instruction queue.
// Optional feature macro IFETCH_ALIGN_FAULT_EN: a misaligned fetch_pc blocks requests and raises fetch_fault.
module ifetch_unit #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] L_QDEPTH = (CW + 1)'(QDEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_q_data [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];

    logic          w_fault;
    logic          w_req_fire;
    logic          w_rsp_push;
    logic          w_rsp_drop;
    logic          w_pop;
    logic [CW:0]   w_inflight;

`ifdef IFETCH_ALIGN_FAULT_EN
    assign w_fault       = !rst && (r_fetch_pc[1:0] != 2'b00);
    assign imem_req_addr = r_fetch_pc;
`else
    assign w_fault       = 1'b0;
    assign imem_req_addr = {r_fetch_pc[31:2], 2'b00};
`endif
    assign fetch_fault = w_fault;

    // Every outstanding request owns a queue slot, so a response can always be pushed.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid = !rst && !redirect_valid && !w_fault && (w_inflight < L_QDEPTH);
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_drop     = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
    assign w_rsp_push     = imem_rsp_valid && !w_rsp_drop;

    assign inst_valid = (r_count != '0);
    assign inst_data  = r_q_data[r_rptr];
    assign inst_pc    = r_q_pc[r_rptr];
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= pc_start;
            r_rsp_pc      <= pc_start;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight is stale; a response arriving now is already one of them.
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wptr   <= r_wptr + PW'(1);
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_count <= r_count + CW'(w_rsp_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_q_data[r_wptr] <= imem_rsp_data;
            r_q_pc[r_wptr]   <= r_rsp_pc;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a streaming vector table on a 4-deep instance, then directed corner
// sequences and random traffic on a 2-deep instance checked against a queue-based reference model.
module tb_ifetch_unit;
    localparam int QD = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc_start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    logic        req_valid4, req_ready4, rsp_valid4, inst_valid4, fault4;
    logic [31:0] req_addr4, rsp_data4, inst_data4, inst_pc4;

    ifetch_unit #(.QDEPTH(QD)) u_dut (
        .clk(clk), .rst(rst), .pc_start(pc_start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    ifetch_unit #(.QDEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .pc_start(pc_start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(req_valid4), .imem_req_ready(req_ready4), .imem_req_addr(req_addr4),
        .imem_rsp_valid(rsp_valid4), .imem_rsp_data(rsp_data4),
        .inst_valid(inst_valid4), .inst_ready(inst_ready), .inst_data(inst_data4), .inst_pc(inst_pc4),
        .fetch_fault(fault4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          rdy;
        bit          rsp;
        logic [31:0] rsp_addr;
        bit          ird;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    ent_t        iq[$];
    bit          inflight[$];
    logic [31:0] mem_q[$];
    logic [31:0] m_fetch_pc, m_rsp_pc;
    int          n_vec, n_fail, n_acc;
    bit          saw_wrap;
    vec_t        tbl[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic bit m_fault();
`ifdef IFETCH_ALIGN_FAULT_EN
        return m_fetch_pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_addr();
`ifdef IFETCH_ALIGN_FAULT_EN
        return m_fetch_pc;
`else
        return {m_fetch_pc[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req_valid(input bit rv);
        return !rv && !m_fault() && (inflight.size() + iq.size() < QD);
    endfunction

    task automatic check_model();
        chk("req_valid", 32'(imem_req_valid), 32'(m_req_valid(redirect_valid)));
        chk("req_addr", imem_req_addr, m_addr());
        chk("inst_valid", 32'(inst_valid), 32'(iq.size() > 0));
        if (iq.size() > 0) begin
            chk("inst_pc", inst_pc, iq[0].pc);
            chk("inst_data", inst_data, iq[0].data);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault()));
    endtask

    task automatic advance_model(input bit rv, input logic [31:0] rpc, input bit rdy, input bit ird);
        bit erv;
        bit live;
        erv = m_req_valid(rv);
        if (!rv && ird && iq.size() > 0) void'(iq.pop_front());
        if (imem_rsp_valid && inflight.size() > 0) begin
            live = inflight.pop_front();
            if (live && !rv) begin
                iq.push_back('{m_rsp_pc, mem_word({m_rsp_pc[31:2], 2'b00})});
                m_rsp_pc = m_rsp_pc + 32'd4;
            end
        end
        if (erv && rdy) begin
            inflight.push_back(1'b1);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (rv) begin
            iq.delete();
            foreach (inflight[i]) inflight[i] = 1'b0;
            m_fetch_pc = rpc;
            m_rsp_pc   = rpc;
        end
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit rsp_en, input bit ird);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        inst_ready     = ird;
        imem_rsp_valid = rsp_en && (mem_q.size() > 0);
        imem_rsp_data  = 32'h0;
        if (imem_rsp_valid) imem_rsp_data = mem_word(mem_q[0]);
        @(negedge clk);
        check_model();
        advance_model(rv, rpc, rdy, ird);
        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            n_acc++;
            if (imem_req_addr == 32'h0) saw_wrap = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [31:0] pcs);
        pc_start       = pcs;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        rst            = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        chk("rst_req_addr", imem_req_addr, pcs);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        iq.delete();
        inflight.delete();
        mem_q.delete();
        m_fetch_pc = pcs;
        m_rsp_pc   = pcs;
    endtask

    initial begin
        bit          rv, rdy, rsp_en, ird;
        logic [31:0] rpc, held_pc;
        n_vec = 0; n_fail = 0; n_acc = 0; saw_wrap = 1'b0;
        req_ready4 = 1'b0; rsp_valid4 = 1'b0; rsp_data4 = 32'h0;
        redirect_pc = 32'h0; imem_rsp_data = 32'h0;

        tbl[0] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h1000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h1004, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h1004, 1'b1, 1'b1, 32'h1008, 1'b1, 32'h1000};
        tbl[3] = '{1'b1, 1'b1, 32'h1008, 1'b1, 1'b1, 32'h100C, 1'b1, 32'h1004};
        tbl[4] = '{1'b1, 1'b1, 32'h100C, 1'b1, 1'b1, 32'h1010, 1'b1, 32'h1008};
        tbl[5] = '{1'b0, 1'b1, 32'h1010, 1'b1, 1'b1, 32'h1014, 1'b1, 32'h100C};
        tbl[6] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h1014, 1'b1, 32'h1010};
        tbl[7] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h1014, 1'b0, 32'h0};

        reset_dut(32'h1000);
        for (int i = 0; i < 8; i++) begin
            req_ready4 = tbl[i].rdy;
            rsp_valid4 = tbl[i].rsp;
            rsp_data4  = tbl[i].rsp ? mem_word(tbl[i].rsp_addr) : 32'h0;
            inst_ready = tbl[i].ird;
            @(negedge clk);
            chk("tbl_req_valid", 32'(req_valid4), 32'(tbl[i].e_req));
            chk("tbl_req_addr", req_addr4, tbl[i].e_addr);
            chk("tbl_inst_valid", 32'(inst_valid4), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk("tbl_inst_pc", inst_pc4, tbl[i].e_pc);
                chk("tbl_inst_data", inst_data4, mem_word(tbl[i].e_pc));
            end
            @(posedge clk);
            #1;
        end
        req_ready4 = 1'b0;
        rsp_valid4 = 1'b0;

        // Back-pressure: only QD requests fit, head held while stalled.
        reset_dut(32'h1000);
        n_acc = 0;
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        held_pc = inst_pc;
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("stall_accepts", n_acc, 32'd2);
        chk("stall_hold_pc", inst_pc, held_pc);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Redirect with two requests outstanding.
        reset_dut(32'h1000);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h2000, 1'b1, 1'b0, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("redir_valid", 32'(inst_valid), 32'h1);
        chk("redir_first_pc", inst_pc, 32'h2000);

        // Redirect coinciding with a response and a pop.
        reset_dut(32'h1000);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h3000, 1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("redir_rsp_pop_pc", inst_pc, 32'h3000);

        // Address wrap, then misaligned redirect.
        reset_dut(32'h1000);
        saw_wrap = 1'b0;
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("wrap_to_zero", 32'(saw_wrap), 32'h1);
        step(1'b1, 32'h2002, 1'b1, 1'b1, 1'b1);
`ifdef IFETCH_ALIGN_FAULT_EN
        chk("misalign_fault", 32'(fetch_fault), 32'h1);
        chk("misalign_noreq", 32'(imem_req_valid), 32'h0);
        chk("misalign_addr", imem_req_addr, 32'h2002);
`else
        chk("misalign_fault", 32'(fetch_fault), 32'h0);
        chk("misalign_addr", imem_req_addr, 32'h2000);
`endif
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h3000, 1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Reset mid-operation with traffic in flight.
        reset_dut(32'h1000);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        reset_dut(32'h4000);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            rv     = ($urandom_range(0, 24) == 0);
            rpc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            rdy    = ($urandom_range(0, 3) != 0);
            rsp_en = ($urandom_range(0, 4) < 3);
            ird    = ($urandom_range(0, 9) < 7);
            step(rv, rpc, rdy, rsp_en, ird);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
